// File: rtl/forex_pkg.sv
// forex_ctrl shared types: FSM states, register map, update record.
// Defaults mirror the arbitrage engine's Const.vh build values.
package forex_pkg;

  localparam int N_CUR_DEF      = 8;
  localparam int WEIGHT_W_DEF   = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int PRED_W_DEF     = $clog2(N_CUR_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_POST
  } state_t;

  localparam logic [2:0] A_STAGE  = 3'd0;
  localparam logic [2:0] A_WEIGHT = 3'd1;
  localparam logic [2:0] A_CTRL   = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_COUNT  = 3'd4;
  localparam logic [2:0] A_LAST   = 3'd5;

  typedef struct packed {
    logic [PRED_W_DEF-1:0]   src;
    logic [PRED_W_DEF-1:0]   dst;
    logic [WEIGHT_W_DEF-1:0] weight;
  } upd_t;

endpackage

// File: rtl/forex_if.sv
// Avalon-MM slave and engine start/done bundle for forex_ctrl.
// slave faces the controller; master faces host plus engine.
interface forex_if #(
  parameter int PRED_W   = 3,
  parameter int WEIGHT_W = 32
);

  logic                chipselect;
  logic                write;
  logic                read;
  logic [2:0]          address;
  logic [31:0]         writedata;
  logic [31:0]         readdata;
  logic                irq;
  logic                eng_start;
  logic [PRED_W-1:0]   eng_src;
  logic [PRED_W-1:0]   eng_dst;
  logic [WEIGHT_W-1:0] eng_weight;
  logic                eng_done;
  logic                eng_cycle;

  modport slave (
    input  chipselect, write, read,
    input  address, writedata,
    input  eng_done, eng_cycle,
    output readdata, irq,
    output eng_start, eng_src,
    output eng_dst, eng_weight
  );

  modport master (
    output chipselect, write, read,
    output address, writedata,
    output eng_done, eng_cycle,
    input  readdata, irq,
    input  eng_start, eng_src,
    input  eng_dst, eng_weight
  );

endinterface

// File: rtl/forex_fifo.sv
// Synchronous update queue with flush; flush beats push and pop.
// A push into a full queue is accepted when a pop frees a slot.
module forex_fifo
  import forex_pkg::*;
#(
  parameter type T     = upd_t,
  parameter int  DEPTH = FIFO_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  T              wdata,
  output T              rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/forex_ctrl.sv
// Avalon-MM control peripheral queueing edge updates for the
// arbitrage graph engine; register decode, flags and engine FSM.
module forex_ctrl
  import forex_pkg::*;
#(
  parameter int  N_CUR      = N_CUR_DEF,
  parameter int  WEIGHT_W   = WEIGHT_W_DEF,
  parameter int  FIFO_DEPTH = FIFO_DEPTH_DEF,
  localparam int PRED_W     = $clog2(N_CUR),
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input logic     clk,
  input logic     reset_n,
  forex_if.slave  bus
);

  typedef struct packed {
    logic [PRED_W-1:0]   src;
    logic [PRED_W-1:0]   dst;
    logic [WEIGHT_W-1:0] weight;
  } rec_t;

  state_t              state_q, state_d;
  logic [PRED_W-1:0]   stg_src_q, stg_src_d;
  logic [PRED_W-1:0]   stg_dst_q, stg_dst_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic                cyc_q, cyc_d;
  logic                ovf_q, ovf_d;
  logic                err_q, err_d;
  logic [15:0]         upd_cnt_q, upd_cnt_d;
  logic [PRED_W-1:0]   last_src_q, last_src_d;
  logic [PRED_W-1:0]   last_dst_q, last_dst_d;
  logic                start_q, start_d;
  logic [PRED_W-1:0]   src_q, src_d;
  logic [PRED_W-1:0]   dst_q, dst_d;
  logic [WEIGHT_W-1:0] wgt_q, wgt_d;
  logic [31:0]         rdata_q, rdata_d;

  logic        wr_stage, wr_weight, wr_ctrl;
  logic        rd;
  logic        clr, flush;
  logic        range_bad, bad_ep;
  logic        push_ok, pop;
  logic        eng_fire;
  logic        busy;
  logic [31:0] status;
  rec_t        wrec, head;
  logic [CW-1:0] fcnt;
  logic        ffull, fempty;
  logic        unused_ok;

  assign unused_ok = ^bus.writedata;
  assign rd = bus.chipselect & bus.read;

  always_comb begin
    wr_stage  = 1'b0;
    wr_weight = 1'b0;
    wr_ctrl   = 1'b0;
    if (bus.chipselect & bus.write) begin
      unique case (bus.address)
        A_STAGE:  wr_stage  = 1'b1;
        A_WEIGHT: wr_weight = 1'b1;
        A_CTRL:   wr_ctrl   = 1'b1;
        default:  ;
      endcase
    end
  end

  assign clr   = wr_ctrl & bus.writedata[1];
  assign flush = wr_ctrl & bus.writedata[2];

  // Index range only matters when PRED_W can encode >= N_CUR.
  if ((1 << PRED_W) > N_CUR) begin : g_rng
    assign range_bad = (32'(stg_src_q) >= 32'(N_CUR))
                     | (32'(stg_dst_q) >= 32'(N_CUR));
  end else begin : g_norng
    assign range_bad = 1'b0;
  end

  assign bad_ep   = (stg_src_q == stg_dst_q) | range_bad;
  assign push_ok  = wr_weight & ~bad_ep;
  assign pop      = (state_q == S_IDLE) & ~fempty & ~flush;
  assign eng_fire = (state_q == S_RUN) & bus.eng_done;
  assign busy     = (state_q != S_IDLE);
  assign wrec     = {stg_src_q, stg_dst_q,
                     bus.writedata[WEIGHT_W-1:0]};

  forex_fifo #(
    .T     (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset_n),
    .flush (flush),
    .push  (push_ok),
    .pop   (pop),
    .wdata (wrec),
    .rdata (head),
    .count (fcnt),
    .full  (ffull),
    .empty (fempty)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (pop) state_d = S_LOAD;
      S_LOAD:  state_d = S_RUN;
      S_RUN:   if (bus.eng_done) state_d = S_POST;
      S_POST:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    stg_src_d  = stg_src_q;
    stg_dst_d  = stg_dst_q;
    irq_en_d   = irq_en_q;
    upd_cnt_d  = upd_cnt_q;
    last_src_d = last_src_q;
    last_dst_d = last_dst_q;
    src_d      = src_q;
    dst_d      = dst_q;
    wgt_d      = wgt_q;
    start_d    = (state_q == S_LOAD);
    if (wr_stage) begin
      stg_src_d = bus.writedata[2*PRED_W-1:PRED_W];
      stg_dst_d = bus.writedata[PRED_W-1:0];
    end
    if (wr_ctrl) irq_en_d = bus.writedata[0];
    if (pop) begin
      src_d = head.src;
      dst_d = head.dst;
      wgt_d = head.weight;
    end
    if (eng_fire) begin
      upd_cnt_d = upd_cnt_q + 16'd1;
      if (bus.eng_cycle) begin
        last_src_d = src_q;
        last_dst_d = dst_q;
      end
    end
    // Sticky flags: a set in the clearing cycle survives.
    done_d = (done_q & ~clr) | (state_q == S_POST);
    cyc_d  = (cyc_q & ~clr) | (eng_fire & bus.eng_cycle);
    ovf_d  = (ovf_q & ~clr) | (push_ok & ffull & ~pop & ~flush);
    err_d  = (err_q & ~clr) | (wr_weight & bad_ep & ~flush);
  end

  always_comb begin
    status           = '0;
    status[0]        = busy;
    status[1]        = fempty;
    status[2]        = ffull;
    status[3]        = done_q;
    status[4]        = cyc_q;
    status[5]        = ovf_q;
    status[6]        = err_q;
    status[8 +: CW]  = fcnt;
  end

  always_comb begin
    rdata_d = '0;
    if (rd) begin
      unique case (bus.address)
        A_CTRL:   rdata_d = {31'b0, irq_en_q};
        A_STATUS: rdata_d = status;
        A_COUNT:  rdata_d = {16'b0, upd_cnt_q};
        A_LAST:   rdata_d = 32'({last_src_q, last_dst_q});
        default:  rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      stg_src_q  <= '0;
      stg_dst_q  <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      cyc_q      <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
      upd_cnt_q  <= '0;
      last_src_q <= '0;
      last_dst_q <= '0;
      start_q    <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      wgt_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      stg_src_q  <= stg_src_d;
      stg_dst_q  <= stg_dst_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      cyc_q      <= cyc_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
      upd_cnt_q  <= upd_cnt_d;
      last_src_q <= last_src_d;
      last_dst_q <= last_dst_d;
      start_q    <= start_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      wgt_q      <= wgt_d;
      rdata_q    <= rdata_d;
    end
  end

  assign bus.readdata   = rdata_q;
  assign bus.irq        = done_q & irq_en_q;
  assign bus.eng_start  = start_q;
  assign bus.eng_src    = src_q;
  assign bus.eng_dst    = dst_q;
  assign bus.eng_weight = wgt_q;

endmodule
